// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard controller and its multiply occupancy FSM.
// Forwarding helpers are only referenced when HAZARD_FWD_EN is defined.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_t;

  localparam logic [3:0] PC_TAG = 4'd15;

  // A producer only counts when it writes and the tag is not the PC.
  function automatic logic tag_hit(input logic [3:0] ra, input logic [3:0] wa, input logic we);
    return we && (wa == ra) && (ra != PC_TAG);
  endfunction

  function automatic fwd_sel_t fwd_pick(input logic [3:0] ra,
                                        input logic [3:0] wa_m, input logic we_m,
                                        input logic [3:0] wa_w, input logic we_w);
    if (tag_hit(ra, wa_m, we_m)) return FWD_M;
    if (tag_hit(ra, wa_w, we_w)) return FWD_W;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_mul_fsm.sv
// Multi-cycle multiply occupancy tracker: holds the multiply in E for MUL_LAT cycles
// by asserting MulStall in all but its final E cycle.
module hazard_mul_fsm
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int CW      = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic MulStartE,
  output logic MulStall,
  output logic MulBusy
);

  localparam int            LOAD_I   = (MUL_LAT > 1) ? (MUL_LAT - 2) : 0;
  localparam logic [CW-1:0] CNT_LOAD = LOAD_I[CW-1:0];
  localparam logic          MULTI    = (MUL_LAT > 1);

  mul_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    MulStall = 1'b0;
    case (state_q)
      IDLE: begin
        if (MulStartE && MULTI) begin
          state_d  = BUSY;
          cnt_d    = CNT_LOAD;
          MulStall = 1'b1;
        end
      end
      BUSY: begin
        // cnt == 0 marks the multiply's last E cycle: release the pipeline.
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d    = cnt_q - 1'b1;
          MulStall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign MulBusy = (state_q == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: forwarding, stalls, flushes, M/W tag shadow.
// HAZARD_FWD_EN defined enables forwarding; undefined replaces it with a full RAW stall.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int CW      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic       RegWriteE,
  input  logic       MemtoRegE,
  input  logic       BranchTakenE,
  input  logic       MulStartE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       MulBusy
);

  logic [3:0] wa3_m_q, wa3_m_d, wa3_w_q, wa3_w_d;
  logic       reg_write_m_q, reg_write_m_d, reg_write_w_q, reg_write_w_d;
  logic       mul_stall, ld_stall, load_use;
  fwd_sel_t   fwd_a, fwd_b;

  hazard_mul_fsm #(.MUL_LAT(MUL_LAT), .CW(CW)) u_mul (
    .clk      (clk),
    .reset    (reset),
    .MulStartE(MulStartE),
    .MulStall (mul_stall),
    .MulBusy  (MulBusy)
  );

  assign load_use = MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));

`ifdef HAZARD_FWD_EN
  always_comb begin
    fwd_a    = fwd_pick(RA1E, wa3_m_q, reg_write_m_q, wa3_w_q, reg_write_w_q);
    fwd_b    = fwd_pick(RA2E, wa3_m_q, reg_write_m_q, wa3_w_q, reg_write_w_q);
    ld_stall = load_use;
  end
`else
  logic unused_e_tags;
  assign unused_e_tags = ^{RA1E, RA2E};

  // Without forwarding, D waits until every in-flight producer of its sources has left W.
  always_comb begin
    fwd_a    = FWD_RF;
    fwd_b    = FWD_RF;
    ld_stall = load_use
             | tag_hit(RA1D, WA3E, RegWriteE)
             | tag_hit(RA1D, wa3_m_q, reg_write_m_q)
             | tag_hit(RA1D, wa3_w_q, reg_write_w_q)
             | tag_hit(RA2D, WA3E, RegWriteE)
             | tag_hit(RA2D, wa3_m_q, reg_write_m_q)
             | tag_hit(RA2D, wa3_w_q, reg_write_w_q);
  end
`endif

  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;
  assign StallE    = mul_stall;
  assign StallF    = ld_stall | mul_stall;
  assign StallD    = ld_stall | mul_stall;
  assign FlushE    = (ld_stall | BranchTakenE) & ~mul_stall;
  assign FlushD    = BranchTakenE & ~mul_stall;
  assign FlushM    = mul_stall;

  always_comb begin
    wa3_m_d       = wa3_m_q;
    reg_write_m_d = 1'b0;
    if (!StallE && !FlushE) begin
      wa3_m_d       = WA3E;
      reg_write_m_d = RegWriteE;
    end
    wa3_w_d       = wa3_m_q;
    reg_write_w_d = reg_write_m_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wa3_m_q       <= '0;
      wa3_w_q       <= '0;
      reg_write_m_q <= 1'b0;
      reg_write_w_q <= 1'b0;
    end else begin
      wa3_m_q       <= wa3_m_d;
      wa3_w_q       <= wa3_w_d;
      reg_write_m_q <= reg_write_m_d;
      reg_write_w_q <= reg_write_w_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, async reset mid-multiply, then random
// stimulus against a cycle-level reference model.
module tb_hazard_ctrl;

  localparam int MUL_LAT = 3;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk, reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E;
  logic       RegWriteE, MemtoRegE, BranchTakenE, MulStartE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy;

  hazard_ctrl #(.MUL_LAT(MUL_LAT), .CW(2)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE),
    .MulStartE(MulStartE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .MulBusy(MulBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: destination tags in M and W, and remaining E cycles of a multiply.
  int m_tag, w_tag, mul_rem;
  bit m_we, w_we;

  typedef struct {
    logic [3:0]  ra1d, ra2d, ra1e, ra2e, wa3e;
    logic        rwe, mre, bt, ms;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(input logic [3:0] a1d, a2d, a1e, a2e, wa, input logic rw, mr, b, m,
                              input logic [10:0] e);
    vec_t v;
    v.ra1d = a1d; v.ra2d = a2d; v.ra1e = a1e; v.ra2e = a2e; v.wa3e = wa;
    v.rwe = rw; v.mre = mr; v.bt = b; v.ms = m; v.exp = e;
    return v;
  endfunction

  function automatic logic [10:0] outs();
    return {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy};
  endfunction

  task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_tag = 0; w_tag = 0; m_we = 0; w_we = 0; mul_rem = 0;
  endtask

  function automatic bit hit(input int ra, input int wa, input bit we);
    return we && (wa == ra) && (ra != 15);
  endfunction

  function automatic logic [1:0] ref_fwd(input int ra);
    if (!FWD) return 2'b00;
    if (hit(ra, m_tag, m_we)) return 2'b10;
    if (hit(ra, w_tag, w_we)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_raw(input int ra);
    return hit(ra, int'(WA3E), RegWriteE) || hit(ra, m_tag, m_we) || hit(ra, w_tag, w_we);
  endfunction

  // One clock: evaluate at negedge, compare (table value or model), advance model at posedge.
  task automatic step(input string nm, input bit use_tbl, input logic [10:0] tbl_exp);
    int  rn;
    bit  ms, busy, ld, fe;
    logic [10:0] e;
    @(negedge clk);
    rn   = (mul_rem == 0 && MulStartE) ? MUL_LAT : mul_rem;
    ms   = rn > 1;
    busy = mul_rem > 0;
    ld   = MemtoRegE && RegWriteE && (WA3E == RA1D || WA3E == RA2D);
    if (!FWD) ld = ld || ref_raw(int'(RA1D)) || ref_raw(int'(RA2D));
    fe   = (ld || BranchTakenE) && !ms;
    e    = {ref_fwd(int'(RA1E)), ref_fwd(int'(RA2E)), ld || ms, ld || ms, ms,
            BranchTakenE && !ms, fe, ms, busy};
    check(nm, outs(), use_tbl ? tbl_exp : e);
    @(posedge clk);
    w_tag = m_tag; w_we = m_we;
    if (!ms && !fe) begin
      m_tag = int'(WA3E); m_we = RegWriteE;
    end else begin
      m_we = 1'b0;
    end
    mul_rem = (rn > 0) ? rn - 1 : 0;
    if (reset) model_reset();
    #1;
  endtask

  task automatic apply(input vec_t v);
    RA1D = v.ra1d; RA2D = v.ra2d; RA1E = v.ra1e; RA2E = v.ra2e; WA3E = v.wa3e;
    RegWriteE = v.rwe; MemtoRegE = v.mre; BranchTakenE = v.bt; MulStartE = v.ms;
  endtask

  function automatic logic [3:0] rtag();
    case ($urandom_range(0, 4))
      0: return 4'd0;
      1: return 4'd1;
      2: return 4'd2;
      3: return 4'd3;
      default: return 4'd15;
    endcase
  endfunction

  initial begin
    logic [1:0] fa1, fb2, fb6;
    logic [6:0] raw;
    fa1 = FWD ? 2'b10 : 2'b00;
    fb2 = FWD ? 2'b01 : 2'b00;
    fb6 = FWD ? 2'b01 : 2'b00;
    raw = FWD ? 7'b0000000 : 7'b1100100;
    //            ra1d   ra2d   ra1e   ra2e   wa3e   rw mr bt ms  expected outputs
    tbl[0]  = mk(4'd14, 4'd14, 4'd0,  4'd0,  4'd2,  1, 0, 0, 0, {2'b00, 2'b00, 7'b0000000});
    tbl[1]  = mk(4'd14, 4'd14, 4'd2,  4'd0,  4'd5,  1, 0, 0, 0, {fa1,   2'b00, 7'b0000000});
    tbl[2]  = mk(4'd14, 4'd14, 4'd15, 4'd2,  4'd7,  0, 0, 0, 0, {2'b00, fb2,   7'b0000000});
    tbl[3]  = mk(4'd14, 4'd14, 4'd0,  4'd0,  4'd0,  0, 0, 1, 0, {2'b00, 2'b00, 7'b0001100});
    tbl[4]  = mk(4'd14, 4'd14, 4'd0,  4'd0,  4'd3,  1, 1, 0, 0, {2'b00, 2'b00, 7'b0000000});
    tbl[5]  = mk(4'd14, 4'd3,  4'd0,  4'd0,  4'd3,  1, 1, 0, 0, {2'b00, 2'b00, 7'b1100100});
    tbl[6]  = mk(4'd14, 4'd14, 4'd0,  4'd3,  4'd0,  0, 0, 0, 0, {2'b00, fb6,   7'b0000000});
    tbl[7]  = mk(4'd14, 4'd14, 4'd0,  4'd0,  4'd0,  0, 0, 0, 1, {2'b00, 2'b00, 7'b1110010});
    tbl[8]  = mk(4'd14, 4'd14, 4'd0,  4'd0,  4'd0,  0, 0, 1, 1, {2'b00, 2'b00, 7'b1110011});
    tbl[9]  = mk(4'd14, 4'd14, 4'd0,  4'd0,  4'd0,  0, 0, 1, 1, {2'b00, 2'b00, 7'b0001101});
    tbl[10] = mk(4'd14, 4'd14, 4'd0,  4'd0,  4'd0,  0, 0, 0, 0, {2'b00, 2'b00, 7'b0000000});
    tbl[11] = mk(4'd14, 4'd14, 4'd0,  4'd0,  4'd2,  1, 0, 0, 0, {2'b00, 2'b00, 7'b0000000});
    tbl[12] = mk(4'd2,  4'd14, 4'd0,  4'd0,  4'd0,  0, 0, 0, 0, {2'b00, 2'b00, raw});
    tbl[13] = mk(4'd2,  4'd14, 4'd0,  4'd0,  4'd0,  0, 0, 0, 0, {2'b00, 2'b00, raw});
    tbl[14] = mk(4'd2,  4'd14, 4'd0,  4'd0,  4'd0,  0, 0, 0, 0, {2'b00, 2'b00, 7'b0000000});
    tbl[15] = mk(4'd15, 4'd14, 4'd0,  4'd0,  4'd15, 1, 0, 0, 0, {2'b00, 2'b00, 7'b0000000});

    reset = 1'b1;
    apply(mk(4'd14, 4'd14, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 11'd0));
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outs", outs(), 11'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i]);
      step($sformatf("tbl%0d", i), 1'b1, tbl[i].exp);
    end

    // Asynchronous reset during the first BUSY cycle of a multiply.
    apply(mk(4'd14, 4'd14, 4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 11'd0));
    step("mul_start", 1'b0, 11'd0);
    check("mul_busy_before_rst", {10'd0, MulBusy}, 11'd1);
    #2;
    reset = 1'b1;
    apply(mk(4'd14, 4'd14, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 11'd0));
    #1;
    check("async_rst_outs", outs(), 11'd0);
    model_reset();
    step("rst_held", 1'b0, 11'd0);
    reset = 1'b0;
    step("after_rst", 1'b0, 11'd0);

    for (int n = 0; n < 600; n++) begin
      RA1D = rtag(); RA2D = rtag(); RA1E = rtag(); RA2E = rtag(); WA3E = rtag();
      RegWriteE    = ($urandom_range(0, 1) == 1);
      MemtoRegE    = ($urandom_range(0, 3) == 0);
      BranchTakenE = ($urandom_range(0, 7) == 0);
      MulStartE    = ($urandom_range(0, 5) == 0);
      step($sformatf("rand%0d", n), 1'b0, 11'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core (F/D/E/M/W). It consumes the register tags held in the D/E pipeline register (RA1E, RA2E, WA3E) and the decode-stage source tags.
- Produces forwarding selects, stall enables and flush/clear strobes for all pipeline registers. The D/E register is driven with en = ~StallE, clr = FlushE.
- Keeps its own M/W destination-tag shadow pipeline and a multi-cycle multiply occupancy FSM.

Parameters:
- MUL_LAT, 3, cycles a multiply occupies E (>=1; 1 = no stall).
- CW, 2, counter width; must hold MUL_LAT-1.

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- RA1D  in  4  decode source tag 1
- RA2D  in  4  decode source tag 2
- RA1E  in  4  execute source tag 1
- RA2E  in  4  execute source tag 2
- WA3E  in  4  execute destination tag
- RegWriteE  in  1  E instruction writes the register file
- MemtoRegE  in  1  E instruction is a load
- BranchTakenE  in  1  branch resolved taken in E
- MulStartE  in  1  E instruction is a multiply
- ForwardAE  out  2  src A select: 00 RF, 01 ResultW, 10 ALUResultM
- ForwardBE  out  2  src B select, same encoding
- StallF  out  1  hold PC
- StallD  out  1  hold F/D register
- StallE  out  1  hold D/E register (en = ~StallE)
- FlushD  out  1  clear F/D register
- FlushE  out  1  clear D/E register
- FlushM  out  1  clear E/M register (bubble behind held multiply)
- MulBusy  out  1  FSM in BUSY

Behaviour:
- Reset: reset is asynchronous, active-high; the clock is clk. On reset: WA3M, WA3W, RegWriteM, RegWriteW = 0 and FSM = IDLE. Mid-operation reset aborts BUSY immediately; all outputs are 0 in the reset cycle, given RegWriteE = MemtoRegE = BranchTakenE = MulStartE = 0.
- Shadow pipeline, per posedge:
  - if StallE = 0 and FlushE = 0: M <= {WA3E, RegWriteE}
  - if FlushE = 1 or StallE = 1: RegWriteM <= 0 (bubble enters M)
  - W <= M, unconditionally
- Forwarding (combinational, per source):
  - 10 if RegWriteM and WA3M == RAxE and RAxE != 15
  - else 01 if RegWriteW and WA3W == RAxE and RAxE != 15
  - else 00
  - M has priority over W.
- LdStall = MemtoRegE & RegWriteE & (WA3E == RA1D | WA3E == RA2D).
- MulStall = (IDLE & MulStartE & MUL_LAT > 1) | (BUSY & cnt != 0).
- FSM:
  - IDLE --MulStartE & MUL_LAT > 1--> BUSY, cnt <= MUL_LAT-2.
  - BUSY: cnt decrements each cycle. Leaving: cnt == 0 -> IDLE, with MulStall = 0 that cycle (the multiply's final E cycle).
  - MulStartE is ignored while in BUSY.
  - MulBusy = (state == BUSY).
- Output equations:
  - StallE = MulStall
  - StallF = StallD = LdStall | MulStall
  - FlushE = (LdStall | BranchTakenE) & ~MulStall
  - FlushD = BranchTakenE & ~MulStall
  - FlushM = MulStall
- Simultaneous events:
  - Branch and load-use in the same cycle: FlushE once, FlushD = 1, StallF/StallD = 1.
  - Branch in the multiply's last E cycle is honoured.
  - Total E occupancy of one multiply = MUL_LAT cycles exactly.

Optional Feature:
- Macro HAZARD_FWD_EN.
- Defined: forwarding as specified.
- Undefined:
  - ForwardAE = ForwardBE = 00 constant.
  - LdStall widens to a RAW stall. It also asserts when a D source matches RegWriteE&WA3E, RegWriteM&WA3M or RegWriteW&WA3W, excluding tag 15.
  - Stall is held until the producer leaves W. The register file is assumed write-first.

Decomposition:
- Package hazard_pkg: fwd_sel_t enum (FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10), PC_TAG = 4'd15, mul_state_t (IDLE, BUSY).
- One sub-module: hazard_mul_fsm (state, counter, MulStall, MulBusy).

Test Plan:
- Reset pulsed mid-BUSY (MUL_LAT = 3, cycle 1 of multiply) -> next cycle MulBusy = 0, all stalls/flushes 0, ForwardAE = 00.
- ADD R2 then SUB reading R2 (RegWriteE = 1, WA3E = 2; next cycle RA1E = 2) -> ForwardAE = 10. Cycle after with RA2E = 2 -> ForwardBE = 01. With RA1E = 15 -> 00.
- Load R3 in E (MemtoRegE = 1, RegWriteE = 1, WA3E = 3), RA2D = 3 -> StallF = StallD = FlushE = 1 for 1 cycle. Next cycle ForwardBE = 01 (no forward from M for the bubble).
- BranchTakenE = 1 with no other hazard -> FlushD = FlushE = 1 for exactly 1 cycle, StallF = 0.
- MulStartE held, MUL_LAT = 3 -> StallE = FlushM = 1 for 2 cycles, MulBusy = 1 for 2 cycles. BranchTakenE asserted during a stall cycle -> FlushE = 0. Third cycle StallE = 0; branch -> FlushD = FlushE = 1.
- HAZARD_FWD_EN undefined: ADD R2 then dependent instruction in D -> StallD = 1 for 3 cycles, ForwardAE = 00 throughout.
